// File: rtl/data_mem_pkg.sv
// data_mem_pkg
// Shared definitions for the data memory controller: access-size encodings,
// controller FSM states and the byte-lane helpers used by the datapath.
// No ports (package).
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    // Misalignment, reserved size or word index beyond the array.
    function automatic logic access_fault(size_t size, logic [31:0] addr, int unsigned depth);
        logic fault;
        fault = 1'b0;
        case (size)
            SZ_BYTE: fault = 1'b0;
            SZ_HALF: fault = addr[0];
            SZ_WORD: fault = (addr[1:0] != 2'b00);
            default: fault = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= depth) begin
            fault = 1'b1;
        end
        return fault;
    endfunction

    // Little-endian lane enables for a store of the given size at byte offset lane.
    function automatic logic [3:0] byte_en(size_t size, logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data across lanes; the enables pick the live copy.
    function automatic logic [31:0] place_wdata(size_t size, logic [31:0] wdata);
        logic [31:0] placed;
        case (size)
            SZ_BYTE: placed = {4{wdata[7:0]}};
            SZ_HALF: placed = {2{wdata[15:0]}};
            default: placed = wdata;
        endcase
        return placed;
    endfunction

    // Select the addressed lanes of a word and extend to 32 bits.
    function automatic logic [31:0] extract_rdata(size_t size, logic is_unsigned,
                                                  logic [1:0] lane, logic [31:0] word);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {lane, 3'b000};
        case (size)
            SZ_BYTE: result = is_unsigned ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: result = is_unsigned ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: result = word;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// data_mem_if
// Request/response bus between a load/store master and data_mem_ctrl.
//   req_valid/req_ready : request handshake
//   req_write, req_size, req_unsigned, req_addr, req_wdata : request fields
//   resp_valid, resp_rdata, resp_err : one-cycle response
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_array.sv
// data_mem_array
// DEPTH x 32 storage built as four byte-wide lanes so each lane maps onto a
// block RAM with its own write enable. Synchronous write and read, no reset.
//   clk     : clock
//   wr_en   : write strobe, wr_be selects lanes, wr_addr/wr_data word and data
//   rd_en   : read strobe, rd_addr word index, rd_data registered result
module data_mem_array #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [3:0]    wr_be,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_byte_reg;

        always_ff @(posedge clk) begin
            if (wr_en && wr_be[gi]) begin
                mem[wr_addr] <= wr_data[gi*8 +: 8];
            end
            if (rd_en) begin
                rd_byte_reg <= mem[rd_addr];
            end
        end

        assign rd_data[gi*8 +: 8] = rd_byte_reg;
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// Single-outstanding load/store controller in front of data_mem_array.
// Accepts a request in IDLE, optionally waits WAIT_CYCLES cycles, then
// commits the store / performs the read on the edge entering RESP and
// pulses resp_valid for one cycle.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : data_mem_if slave (request handshake + response)
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    data_mem_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    state_t      state_reg;
    logic [2:0]  wait_cnt_reg;
    logic        resp_valid_reg;
    logic        resp_err_reg;
    logic        write_reg;
    size_t       size_reg;
    logic        unsigned_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;

    // In IDLE the live request drives the datapath so a zero-wait access can
    // hit the memory on the accepting edge; afterwards the latched copy does.
    logic        cur_write;
    size_t       cur_size;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        fault;
    logic        go_resp;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [31:0] mem_rd_data;

    assign cur_write = (state_reg == IDLE) ? bus.req_write        : write_reg;
    assign cur_size  = (state_reg == IDLE) ? size_t'(bus.req_size) : size_reg;
    assign cur_addr  = (state_reg == IDLE) ? bus.req_addr         : addr_reg;
    assign cur_wdata = (state_reg == IDLE) ? bus.req_wdata        : wdata_reg;

    assign fault = access_fault(cur_size, cur_addr, DEPTH);

    // High in the cycle whose closing edge enters RESP.
    assign go_resp = ((state_reg == IDLE) && bus.req_valid && (WAIT_CYCLES == 0)) ||
                     ((state_reg == WAIT) && (wait_cnt_reg == WAIT_LAST));

    // The array has no reset, so gate its strobes with rst_n to keep a
    // request presented during reset from touching memory.
    assign mem_wr_en = rst_n && go_resp &&  cur_write && !fault;
    assign mem_rd_en = rst_n && go_resp && !cur_write && !fault;

    data_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_be   (byte_en(cur_size, cur_addr[1:0])),
        .wr_addr (cur_addr[AW+1:2]),
        .wr_data (place_wdata(cur_size, cur_wdata)),
        .rd_en   (mem_rd_en),
        .rd_addr (cur_addr[AW+1:2]),
        .rd_data (mem_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= 3'd0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            write_reg      <= 1'b0;
            size_reg       <= SZ_BYTE;
            unsigned_reg   <= 1'b0;
            addr_reg       <= 32'h0;
            wdata_reg      <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_reg    <= bus.req_write;
                        size_reg     <= size_t'(bus.req_size);
                        unsigned_reg <= bus.req_unsigned;
                        addr_reg     <= bus.req_addr;
                        wdata_reg    <= bus.req_wdata;
                        wait_cnt_reg <= 3'd0;
                        if (WAIT_CYCLES == 0) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= fault;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt_reg == WAIT_LAST) begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= fault;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 3'd1;
                    end
                end
                RESP: begin
                    state_reg      <= IDLE;
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                end
                default: begin
                    state_reg      <= IDLE;
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = rst_n && (state_reg == IDLE);
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_err   = resp_err_reg;
    // Stores and faults return zero; loads see the word read on the RESP edge.
    assign bus.resp_rdata = (resp_valid_reg && !resp_err_reg && !write_reg)
                          ? extract_rdata(size_reg, unsigned_reg, addr_reg[1:0], mem_rd_data)
                          : 32'h0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl
// Directed plus randomized bench for data_mem_ctrl with WAIT_CYCLES = 3.
// Expected results come from a byte-addressed reference memory.
module tb_data_mem_ctrl;
    localparam int DEPTH = 128;
    localparam int W     = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_if bus ();

    data_mem_ctrl #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int prev_acc  = -100;

    logic [7:0] model_mem [DEPTH*4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: byte array, little-endian, extension by arithmetic masking.
    function automatic void model(input logic wr, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic err, output logic [31:0] rdata);
        int n;
        logic [31:0] v;
        logic [31:0] mask;
        err = (sz == 2'b11) || (sz == 2'b01 && addr[0]) ||
              (sz == 2'b10 && addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
        rdata = 32'h0;
        if (err) return;
        n = 1 << sz;
        if (wr) begin
            for (int i = 0; i < n; i++) model_mem[addr + i] = wdata[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(model_mem[addr + i]) << (8*i));
            if (n < 4) begin
                mask = (32'h1 << (8*n)) - 32'h1;
                if (!uns && v[8*n-1]) v = v | ~mask;
            end
            rdata = v;
        end
    endfunction

    function automatic logic [31:0] model_word(input int a);
        return {model_mem[a+3], model_mem[a+2], model_mem[a+1], model_mem[a]};
    endfunction

    task automatic txn(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit keep, input bit b2b_chk, input string tag,
                       output logic [31:0] obs_rd, output logic obs_err);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          n;
        int          acc;
        bit          ready_hi;
        @(negedge clk);
        check({tag, " idle_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, " idle_rdata"}, bus.resp_rdata, 32'd0);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
        acc = cyc;
        if (b2b_chk) check({tag, " interval"}, 32'(acc - prev_acc), 32'(2 + W));
        prev_acc = acc;
        model(wr, sz, uns, addr, wdata, exp_err, exp_rd);
        @(posedge clk);
        #1;
        if (keep) begin
            // Junk while busy must be ignored.
            bus.req_write = 1'($urandom);
            bus.req_size  = 2'($urandom);
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
        end else begin
            bus.req_valid = 1'b0;
        end
        n = 0;
        ready_hi = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (bus.req_ready) ready_hi = 1'b1;
        end while (!bus.resp_valid && n < 20);
        check({tag, " latency"}, 32'(n), 32'(1 + W));
        check({tag, " ready_low"}, 32'(ready_hi), 32'd0);
        check({tag, " err"}, 32'(bus.resp_err), 32'(exp_err));
        check({tag, " rdata"}, bus.resp_rdata, exp_rd);
        obs_rd  = bus.resp_rdata;
        obs_err = bus.resp_err;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] old_word;
        bit          seen;
        int          r;
        logic [1:0]  sz;
        logic [31:0] a;

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;

        repeat (3) @(negedge clk);
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst resp_rdata", bus.resp_rdata, 32'd0);
        check("rst resp_err", 32'(bus.resp_err), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst ready", 32'(bus.req_ready), 32'd1);

        for (int w = 0; w < DEPTH; w++) txn(1, 2'b10, 0, 32'(w*4), $urandom, 0, 0, "init", rd, er);

        // Word round trip
        txn(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, "st_w10", rd, er);
        txn(0, 2'b10, 0, 32'h10, 32'h0, 0, 0, "ld_w10", rd, er);
        check("ld_w10 const", rd, 32'hDEADBEEF);

        // Byte store and extensions
        txn(1, 2'b10, 0, 32'h10, 32'h0, 0, 0, "clr_w10", rd, er);
        txn(1, 2'b00, 0, 32'h11, 32'h80, 0, 0, "st_b11", rd, er);
        txn(0, 2'b00, 0, 32'h11, 32'h0, 0, 0, "ld_sb11", rd, er);
        check("ld_sb11 const", rd, 32'hFFFFFF80);
        txn(0, 2'b00, 1, 32'h11, 32'h0, 0, 0, "ld_ub11", rd, er);
        check("ld_ub11 const", rd, 32'h00000080);
        txn(0, 2'b10, 0, 32'h10, 32'h0, 0, 0, "ld_w10b", rd, er);
        check("ld_w10b const", rd, 32'h00008000);

        // Misalignment
        txn(0, 2'b01, 0, 32'h13, 32'h0, 0, 0, "ld_h13", rd, er);
        check("ld_h13 err const", 32'(er), 32'd1);
        txn(1, 2'b10, 0, 32'h12, 32'h12345678, 0, 0, "st_w12", rd, er);
        check("st_w12 err const", 32'(er), 32'd1);
        txn(0, 2'b10, 0, 32'h10, 32'h0, 0, 0, "reread10", rd, er);
        check("reread10 const", rd, 32'h00008000);

        // Out of range and reserved size
        txn(0, 2'b10, 0, 32'(DEPTH*4), 32'h0, 0, 0, "ld_oor", rd, er);
        check("ld_oor err const", 32'(er), 32'd1);
        txn(1, 2'b11, 0, 32'h10, 32'hFFFFFFFF, 0, 0, "st_rsvd", rd, er);
        check("st_rsvd err const", 32'(er), 32'd1);
        txn(0, 2'b10, 0, 32'h10, 32'h0, 0, 0, "reread10b", rd, er);
        check("reread10b const", rd, 32'h00008000);

        // Reset while in WAIT aborts the store
        old_word = model_word(32'h20);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h20;
        bus.req_wdata = ~old_word;
        check("abort ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort resp_valid", 32'(bus.resp_valid), 32'd0);
        check("abort resp_err", 32'(bus.resp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort ready_after", 32'(bus.req_ready), 32'd1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1'b1;
        end
        check("abort no_resp", 32'(seen), 32'd0);
        txn(0, 2'b10, 0, 32'h20, 32'h0, 0, 0, "abort reread", rd, er);
        check("abort word kept", rd, old_word);

        // Randomized single transactions, then back-to-back with valid held high
        for (int k = 0; k < 70; k++) begin
            r = $urandom_range(0, 9);
            sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, DEPTH*4 - 1));
            if ($urandom_range(0, 9) < 7 && sz != 2'b11) a = a & ~((32'h1 << sz) - 32'h1);
            txn(1'($urandom), sz, 1'($urandom), a, $urandom, (k >= 40), (k >= 41), "rand", rd, er);
        end

        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("final idle_valid", 32'(bus.resp_valid), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 128, data words stored (power of two, 16..4096).
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, extra cycles between request accept and response (0..7).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, controller accepts a request this cycle.
REQ-007 SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2, access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port req_unsigned, input, 1, zero-extend loads when 1, sign-extend when 0.
REQ-010 SHALL have port req_addr, input, 32, byte address.
REQ-011 SHALL have port req_wdata, input, 32, store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port resp_valid, output, 1, one-cycle response pulse.
REQ-013 SHALL have port resp_rdata, output, 32, extended load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err, output, 1, access faulted; meaningful only with resp_valid.

Function
REQ-015 SHALL use FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge where req_valid and req_ready are both 1, latching write, size, unsigned, addr and wdata.
REQ-017 SHALL go IDLE->WAIT on accept when WAIT_CYCLES > 0, else IDLE->RESP; WAIT->RESP after exactly WAIT_CYCLES cycles in WAIT; RESP->IDLE unconditionally.
REQ-018 SHALL assert resp_valid for exactly one cycle, in RESP, i.e. 1+WAIT_CYCLES cycles after the accepting edge; one transaction outstanding at most.
REQ-019 SHALL flag misalignment: half with addr[0]=1, word with addr[1:0]!=00.
REQ-020 SHALL flag out-of-range when addr[31:2] >= DEPTH, and flag req_size = 11.
REQ-021 SHALL, on any flag, set resp_err = 1, resp_rdata = 0, and leave memory unmodified.
REQ-022 SHALL store little-endian: byte to lane addr[1:0], half to lanes {addr[1],0} and {addr[1],1}, word to all four lanes; other lanes unchanged.
REQ-023 SHALL commit a store only on the edge entering RESP; a store aborted earlier leaves memory unmodified.
REQ-024 SHALL return load data read from the word at addr[31:2] on the edge entering RESP, lane-selected per REQ-022, then extended to 32 bits per req_unsigned.
REQ-025 SHALL hold resp_rdata and resp_err at 0 whenever resp_valid is 0.
REQ-026 SHALL ignore req_valid and request inputs while not in IDLE.

Reset
REQ-027 SHALL, while rst_n = 0, force state IDLE, wait counter 0, and hold resp_valid = 0, resp_rdata = 0, resp_err = 0; req_ready = 1 once rst_n = 1.
REQ-028 SHALL abort any in-flight transaction on reset without response and without memory write.
REQ-029 SHALL NOT reset memory contents; contents are undefined until written.

Structure
REQ-030 SHALL take size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum from shared package data_mem_pkg.
REQ-031 SHALL instantiate one sub-module data_mem_array: DEPTH x 32 storage, 4-bit byte-write-enable synchronous write, synchronous read, no reset.

Verification
REQ-032 SHALL cover word store 0xDEADBEEF at 0x10, then load word 0x10 -> resp_rdata 0xDEADBEEF, resp_err 0, resp_valid exactly 1+WAIT_CYCLES cycles after each accept.
REQ-033 SHALL cover byte store 0x80 at 0x11 over 0x00000000, then signed byte load 0x11 -> 0xFFFFFF80, unsigned -> 0x00000080, word load 0x10 -> 0x00008000.
REQ-034 SHALL cover half load at 0x13 and word store at 0x12 -> resp_err 1, resp_rdata 0, word 0x10 unchanged on reread.
REQ-035 SHALL cover word load at DEPTH*4 and req_size 11 -> resp_err 1, no memory change.
REQ-036 SHALL cover WAIT_CYCLES=3 store with rst_n pulsed low in WAIT -> no resp_valid, target word unchanged, req_ready 1 after reset release.
REQ-037 SHALL cover req_valid held high continuously -> back-to-back transactions, one per 2+WAIT_CYCLES cycles, req_ready low outside IDLE.
